// File: rtl/vision_pkg.sv
// Shared definitions for the vision result writer: FSM states, header layout
// and the record width.
package vision_pkg;

  localparam int REC_W = 32;

  // Frame header bit fields
  localparam int SEQ_MSB = 31;
  localparam int SEQ_LSB = 24;
  localparam int OVF_BIT = 23;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    REC,
    HDR,
    DONE
  } state_t;

  // Assemble {seq, ovf, 7'b0, count} into a header word.
  function automatic logic [REC_W-1:0] make_header(input logic [7:0]  seq,
                                                   input logic        ovf,
                                                   input logic [15:0] cnt);
    logic [REC_W-1:0] h;
    h                  = '0;
    h[SEQ_MSB:SEQ_LSB] = seq;
    h[OVF_BIT]         = ovf;
    h[CNT_MSB:CNT_LSB] = cnt;
    return h;
  endfunction

endpackage

// File: rtl/vision_result_fifo.sv
// Synchronous FIFO with a show-ahead head. Pointers carry one extra wrap bit so
// full and empty come straight from registers.
module vision_result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write.
  // NOTE: the data array has no reset; the pointers alone define validity, and
  // leaving it unreset lets it map onto plain RAM/register cells.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer update; simultaneous push and pop keeps occupancy unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/vision_result_writer.sv
// Buffers detection records and writes them to consecutive words after a frame
// header slot, then writes the header {seq, ovf, count} and pulses frame_done.
// Outputs for the next bus cycle are loaded on the same edge that pops a
// record, so a record accepted at edge N is on the bus from edge N+1.
module vision_result_writer
  import vision_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int MAX_RECORDS = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REC_W-1:0] rec_data,
  input  logic             rec_valid,
  input  logic             rec_last,
  output logic             rec_ready,
  output logic [7:0]       avm_address,
  output logic [3:0]       avm_byteenable,
  output logic             avm_chipselect,
  output logic             avm_write,
  output logic [REC_W-1:0] avm_writedata,
  input  logic             avm_waitrequest,
  output logic             frame_done
);

  if (BASE_ADDR + MAX_RECORDS > 255) begin : g_bad_addr_range
    $error("vision_result_writer: BASE_ADDR + MAX_RECORDS exceeds 255");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vision_result_writer: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [15:0] MAX_CNT = 16'(MAX_RECORDS);
  localparam logic [7:0]  BASE    = 8'(BASE_ADDR);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      rec_cnt;
  logic [15:0]      cnt_inc;
  logic [15:0]      cnt_sel;
  logic [15:0]      written;
  logic [7:0]       seq;
  logic             ovf;
  logic             cur_last;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [REC_W:0]   head;
  logic             rec_done;
  logic             hdr_done;
  logic             write_nxt;
  logic [7:0]       addr_nxt;
  logic [REC_W-1:0] data_nxt;
  logic             done_nxt;

  vision_result_fifo #(
    .WIDTH (REC_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rec_valid),
    .push_data ({rec_last, rec_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_ready = !fifo_full;

  // In REC a registered avm_write=0 means the record is being discarded.
  assign rec_done = (state == REC) && (!avm_write || !avm_waitrequest);
  assign hdr_done = (state == HDR) && !avm_waitrequest;
  assign pop      = !fifo_empty &&
                    ((state == IDLE) || (rec_done && !cur_last));
  assign cnt_inc  = (rec_cnt == 16'hFFFF) ? rec_cnt : rec_cnt + 16'd1;
  assign cnt_sel  = (state == IDLE) ? rec_cnt : cnt_inc;
  assign written  = (cnt_inc > MAX_CNT) ? MAX_CNT : cnt_inc;

  // State register.
  // NOTE: every clocked block uses <= so all registers see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!fifo_empty) state_nxt = REC;
      REC: begin
        if (rec_done) begin
          if (cur_last)         state_nxt = HDR;
          else if (fifo_empty)  state_nxt = IDLE;
          else                  state_nxt = REC;
        end
      end
      HDR:     if (hdr_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next bus-cycle contents; outputs hold while the slave stalls.
  always_comb begin
    write_nxt = avm_write;
    addr_nxt  = avm_address;
    data_nxt  = avm_writedata;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop) begin
          write_nxt = (cnt_sel < MAX_CNT);
          addr_nxt  = BASE + 8'd1 + cnt_sel[7:0];
          data_nxt  = head[REC_W-1:0];
        end
      end
      REC: begin
        if (rec_done) begin
          if (cur_last) begin
            write_nxt = 1'b1;
            addr_nxt  = BASE;
            data_nxt  = make_header(seq, ovf | !avm_write, written);
          end else if (pop) begin
            write_nxt = (cnt_sel < MAX_CNT);
            addr_nxt  = BASE + 8'd1 + cnt_sel[7:0];
            data_nxt  = head[REC_W-1:0];
          end else begin
            write_nxt = 1'b0;
          end
        end
      end
      HDR: begin
        if (hdr_done) begin
          write_nxt = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      default: write_nxt = 1'b0;
    endcase
  end

  // Registered Avalon outputs and frame_done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_write      <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_byteenable <= 4'h0;
      avm_address    <= 8'h00;
      avm_writedata  <= '0;
      frame_done     <= 1'b0;
    end else begin
      avm_write      <= write_nxt;
      avm_chipselect <= write_nxt;
      avm_byteenable <= {4{write_nxt}};
      avm_address    <= addr_nxt;
      avm_writedata  <= data_nxt;
      frame_done     <= done_nxt;
    end
  end

  // Frame counters: record count, overflow flag, sequence number, last flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_cnt  <= '0;
      ovf      <= 1'b0;
      seq      <= '0;
      cur_last <= 1'b0;
    end else begin
      if (rec_done) begin
        rec_cnt <= cnt_inc;
        if (!avm_write) ovf <= 1'b1;
      end else if (state == DONE) begin
        rec_cnt <= '0;
        ovf     <= 1'b0;
        seq     <= seq + 8'd1;
      end
      if (pop) cur_last <= head[REC_W];
    end
  end

endmodule

// File: tb/tb_vision_result_writer.sv
// Scoreboard bench for vision_result_writer: stimulus pushes expected bus
// writes and frame_done events; a negedge monitor pops and compares them.
module tb_vision_result_writer;

  localparam int MAX_RECORDS = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rec_data = '0;
  logic        rec_valid = 1'b0;
  logic        rec_last = 1'b0;
  logic        rec_ready;
  logic [7:0]  avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        frame_done;

  always #5 clk = ~clk;

  vision_result_writer #(
    .BASE_ADDR   (0),
    .MAX_RECORDS (MAX_RECORDS),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rec_data        (rec_data),
    .rec_valid       (rec_valid),
    .rec_last        (rec_last),
    .rec_ready       (rec_ready),
    .avm_address     (avm_address),
    .avm_byteenable  (avm_byteenable),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .frame_done      (frame_done)
  );

  typedef struct packed {
    logic        is_done;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [7:0]  seq_exp = 8'd0;

  // Slave stall control and hold observation
  bit          stall_en = 1'b0;
  logic [7:0]  stall_addr = 8'd0;
  int          stall_left = 0;
  int          hold_cnt = 0;
  logic [31:0] hold_data = '0;
  bit          hold_bad = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor and slave model: decides waitrequest for the coming edge, then
  // scores every completed write and every frame_done pulse.
  always @(negedge clk) begin
    exp_t e;
    logic wreq;
    if (!reset_n) begin
      avm_waitrequest = 1'b0;
    end else begin
      wreq = 1'b0;
      if (stall_en && avm_write && avm_address == stall_addr) begin
        if (hold_cnt == 0) hold_data = avm_writedata;
        else if (avm_writedata !== hold_data) hold_bad = 1'b1;
        hold_cnt++;
        if (stall_left > 0) begin
          wreq = 1'b1;
          stall_left--;
        end
      end
      avm_waitrequest = wreq;
      if (avm_write && !wreq) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: addr %h data %h, expected none",
                   avm_address, avm_writedata);
        end else begin
          e = exp_q.pop_front();
          check("write", {1'b0, avm_chipselect, avm_byteenable, avm_address, avm_writedata},
                {e.is_done, 1'b1, 4'hF, e.addr, e.data});
        end
      end
      if (!avm_write)
        check("idle_be_cs", {avm_chipselect, avm_byteenable}, 5'b0);
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame_done: got pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          check("frame_done", {frame_done, avm_write}, {e.is_done, 1'b0});
        end
      end
    end
  end

  task automatic expect_rec(input int idx, input logic [31:0] d);
    if (idx < MAX_RECORDS) exp_q.push_back({1'b0, 8'(idx + 1), d});
  endtask

  task automatic expect_hdr(input int n);
    int cnt;
    cnt = (n > MAX_RECORDS) ? MAX_RECORDS : n;
    exp_q.push_back({1'b0, 8'h00, seq_exp, (n > MAX_RECORDS), 7'b0, 16'(cnt)});
    exp_q.push_back({1'b1, 8'h00, 32'h0});
    seq_exp++;
  endtask

  task automatic send_rec(input logic [31:0] d, input logic last, output bit waited);
    rec_data  = d;
    rec_last  = last;
    rec_valid = 1'b1;
    waited    = 1'b0;
    for (int i = 0; i < 200 && !rec_ready; i++) begin
      waited = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!rec_ready) begin
      checks++;
      $display("FAIL send_timeout: rec_ready 0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    rec_valid = 1'b0;
    rec_last  = 1'b0;
  endtask

  task automatic run_frame(input int n, input logic [31:0] base, output bit any_wait);
    bit w;
    any_wait = 1'b0;
    for (int i = 0; i < n; i++) expect_rec(i, base + 32'(i));
    expect_hdr(n);
    for (int i = 0; i < n; i++) begin
      send_rec(base + 32'(i), (i == n - 1), w);
      any_wait |= w;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5000 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    bit w;
    bit anyw;

    // Reset state
    #12;
    check("reset_outputs",
          {avm_write, avm_chipselect, avm_byteenable, avm_address, avm_writedata, frame_done},
          47'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", rec_ready, 1'b1);

    // Frame of A,B,C with literal expectations, plus first-write latency
    exp_q.push_back({1'b0, 8'd1, 32'hAAAA_0001});
    exp_q.push_back({1'b0, 8'd2, 32'hBBBB_0002});
    exp_q.push_back({1'b0, 8'd3, 32'hCCCC_0003});
    exp_q.push_back({1'b0, 8'd0, 32'h0000_0003});
    exp_q.push_back({1'b1, 8'd0, 32'h0});
    seq_exp++;
    send_rec(32'hAAAA_0001, 1'b0, w);
    @(posedge clk);
    #1;
    check("first_write_latency", {avm_write, avm_address}, {1'b1, 8'd1});
    send_rec(32'hBBBB_0002, 1'b0, w);
    send_rec(32'hCCCC_0003, 1'b1, w);
    drain("drain_frame1");

    // Second frame: header carries seq=1
    exp_q.push_back({1'b0, 8'd1, 32'h1111_0001});
    exp_q.push_back({1'b0, 8'd2, 32'h1111_0002});
    exp_q.push_back({1'b0, 8'd3, 32'h1111_0003});
    exp_q.push_back({1'b0, 8'd0, 32'h0100_0003});
    exp_q.push_back({1'b1, 8'd0, 32'h0});
    seq_exp++;
    send_rec(32'h1111_0001, 1'b0, w);
    send_rec(32'h1111_0002, 1'b0, w);
    send_rec(32'h1111_0003, 1'b1, w);
    drain("drain_frame2");

    // Overflow: 20 records, only 16 written, header 0x0280_0010 (seq 2)
    run_frame(20, 32'h5000_0000, anyw);
    drain("drain_overflow");
    // Next frame has ovf cleared (header 0x0300_0001)
    run_frame(1, 32'h6000_0000, anyw);
    drain("drain_after_overflow");

    // Stall record 2 for three cycles
    hold_cnt   = 0;
    hold_bad   = 1'b0;
    stall_addr = 8'd2;
    stall_left = 3;
    stall_en   = 1'b1;
    run_frame(5, 32'h7000_0000, anyw);
    drain("drain_stall");
    stall_en = 1'b0;
    check("stall_hold_cycles", hold_cnt, 4);
    check("stall_data_stable", hold_bad, 1'b0);

    // Long stall on record 1: four further accepts fill the FIFO
    hold_cnt   = 0;
    stall_addr = 8'd1;
    stall_left = 12;
    stall_en   = 1'b1;
    for (int i = 0; i < 7; i++) expect_rec(i, 32'h8000_0000 + 32'(i));
    expect_hdr(7);
    send_rec(32'h8000_0000, 1'b0, w);
    anyw = 1'b0;
    for (int i = 1; i < 5; i++) begin
      send_rec(32'h8000_0000 + 32'(i), 1'b0, w);
      anyw |= w;
    end
    check("fill_no_wait", anyw, 1'b0);
    check("ready_low_when_full", rec_ready, 1'b0);
    send_rec(32'h8000_0005, 1'b0, w);
    send_rec(32'h8000_0006, 1'b1, w);
    drain("drain_fill");
    stall_en = 1'b0;

    // Continuous stream: rec_ready never drops, order preserved
    run_frame(12, 32'h9000_0000, anyw);
    check("continuous_no_wait", anyw, 1'b0);
    drain("drain_continuous");

    // Reset in the middle of record 2's write
    stall_addr = 8'd2;
    stall_left = 40;
    stall_en   = 1'b1;
    run_frame(3, 32'hA000_0000, anyw);
    for (int i = 0; i < 100 && !(avm_write && avm_address == 8'd2); i++) @(negedge clk);
    check("reached_record2", {avm_write, avm_address}, {1'b1, 8'd2});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_write", {avm_write, avm_chipselect, frame_done}, 3'b000);
    exp_q.delete();
    stall_en   = 1'b0;
    stall_left = 0;
    seq_exp    = 8'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ready_after_mid_reset", rec_ready, 1'b1);
    exp_q.push_back({1'b0, 8'd1, 32'hB000_0000});
    exp_q.push_back({1'b0, 8'd0, 32'h0000_0001});
    exp_q.push_back({1'b1, 8'd0, 32'h0});
    seq_exp++;
    send_rec(32'hB000_0000, 1'b1, w);
    drain("drain_after_reset");

    // 256 one-record frames: seq wraps 8'hFF -> 8'h00
    for (int f = 0; f < 256; f++) run_frame(1, 32'hC000_0000 + 32'(f), anyw);
    drain("drain_seq_wrap");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vision_result_writer.md
VISION_RESULT_WRITER -- requirements
Module: vision_result_writer

Interface
REQ-001 Parameter BASE_ADDR, default 0: word address of the frame header in the shared data memory.
REQ-002 Parameter MAX_RECORDS, default 16: maximum records stored per frame. BASE_ADDR+MAX_RECORDS SHALL be <= 255; elaboration SHALL fail otherwise.
REQ-003 Parameter FIFO_DEPTH, default 4: input buffer depth, power of two.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rec_data  in  32  detection record, e.g. packed bounding box.
REQ-007 rec_valid  in  1  rec_data/rec_last valid.
REQ-008 rec_last  in  1  marks the final record of a frame; that record is itself a record.
REQ-009 rec_ready  out  1  buffer can accept a record.
REQ-010 avm_address  out  8  word address, Avalon-MM master.
REQ-011 avm_byteenable  out  4  always 4'hF while avm_write=1.
REQ-012 avm_chipselect  out  1  equal to avm_write.
REQ-013 avm_write  out  1  write request.
REQ-014 avm_writedata  out  32  write data.
REQ-015 avm_waitrequest  in  1  slave stall. Tie to 0 for the fixed-latency on-chip data memory.
REQ-016 frame_done  out  1  one-cycle pulse after the header write completes.

Function
REQ-017 A record SHALL be accepted on a rising edge with rec_valid=1 and rec_ready=1; rec_ready SHALL be 1 exactly when the FIFO is not full, with no combinational path from rec_valid.
REQ-018 The FIFO SHALL store {rec_last, rec_data}, FIFO_DEPTH entries, in order, with no loss or duplication. A push into a full FIFO cannot occur; a simultaneous push and pop when not full SHALL leave occupancy unchanged.
REQ-019 FSM states: IDLE, REC, HDR, DONE.
REQ-020 IDLE: if the FIFO is non-empty, pop the head on the next edge and go to REC.
REQ-021 REC, when rec_cnt < MAX_RECORDS:
- drive avm_write=1, avm_address=BASE_ADDR+1+rec_cnt, avm_writedata=record.
- hold all outputs stable while avm_waitrequest=1.
- the write completes on the edge where avm_write=1 and avm_waitrequest=0.
REQ-022 REC, when rec_cnt >= MAX_RECORDS: discard the record without a bus write and set ovf.
REQ-023 On completion or discard of a record, increment rec_cnt (16-bit, saturating). Then:
- if that record had rec_last=1, go to HDR.
- else if the FIFO is non-empty, pop the next record and stay in REC.
- else go to IDLE.
REQ-024 The frame header SHALL be {seq[7:0], ovf, 7'b0, written_count[15:0]}, where written_count = min(rec_cnt, MAX_RECORDS).
REQ-025 HDR: write the header to BASE_ADDR under the REC handshake rules, then go to DONE on completion.
REQ-026 DONE lasts one cycle:
- frame_done=1.
- rec_cnt clears to 0 and ovf clears to 0.
- seq increments, wrapping 255 to 0.
- next state is IDLE.
REQ-027 The header SHALL always be written after every record write of its frame; a frame of one record SHALL produce exactly two writes.
REQ-028 With avm_waitrequest=0, a record accepted at edge N SHALL have avm_write=1 from edge N+1, giving sustained throughput of one write per cycle.
REQ-029 All Avalon outputs and frame_done SHALL be registered.
REQ-030 While avm_write=0, avm_address and avm_writedata are don't-care, and avm_byteenable=0.

Reset
REQ-031 reset_n low SHALL asynchronously force: state=IDLE, FIFO empty, rec_ready=1 after release, avm_write=0, avm_chipselect=0, avm_byteenable=0, avm_address=0, avm_writedata=0, frame_done=0, rec_cnt=0, ovf=0, seq=0.
REQ-032 Reset mid-frame or mid-write SHALL abandon the frame with no header write; after release, the next record starts a new frame at BASE_ADDR+1.

Structure
REQ-033 Shared package vision_pkg SHALL hold the state enum, the header bit-field positions (SEQ_MSB/LSB, OVF_BIT, CNT_MSB/LSB) and the record width constant.
REQ-034 Sub-module vision_result_fifo (synchronous FIFO, parameters width and depth, full/empty outputs) SHALL be instantiated once; the FSM and counters live in the top module.

Verification
REQ-035 3 records A,B,C (C last), waitrequest=0 -> writes A@1, B@2, C@3, then header 32'h0000_0003@0, then frame_done 1 cycle; second frame header seq=1 (32'h0100_0003).
REQ-036 20 records, MAX_RECORDS=16 -> 16 writes @1..16, none above 16, header 32'h0080_0010, next frame ovf=0.
REQ-037 waitrequest held high 3 cycles on record 2 -> address and data stable for 4 cycles, exactly one write, rec_ready=0 after 4 further accepts with FIFO_DEPTH=4.
REQ-038 Continuous rec_valid, waitrequest=0 -> one write per cycle, rec_ready never drops, record order preserved.
REQ-039 reset_n pulsed low during record 2 of a frame -> avm_write=0 immediately, no header; next frame writes its first record @1 with header seq=0.
REQ-040 256 frames of 1 record each -> seq wraps 8'hFF to 8'h00, every header count=1.
